// File: rtl/nor_pattern_checker.sv
// nor_pattern_checker: steps a 3-input NOR under test through all 8 input vectors and scores its replies
// Ports: clk, rst_n (sync, active-low), start (run request, seen only when idle), x (NOR reply);
//        a/b/c drive the NOR (a=vec[2]); busy spans the run, done pulses at its end;
//        pass/err_count/fail_vec/fail_valid report the last run.
module nor_pattern_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       x,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic       fail_valid
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;
  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d, fv_q, fv_d;
  logic [3:0] cnt_q, cnt_d, err_q, err_d;
  logic       fval_q, fval_d, pass_q, pass_d, mis;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= '0;
      fval_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fval_q  <= fval_d;
      pass_q  <= pass_d;
    end
  end
  // x is only meaningful in SAMPLE, so the mismatch term is gated by state
  assign mis = (state_q == S_SAMPLE) && (x != ~|vec_q);
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fval_d  = fval_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WAIT;
        vec_d   = '0;
        cnt_d   = '0;
        err_d   = '0;
        fv_d    = '0;
        fval_d  = 1'b0;
        pass_d  = 1'b0;
      end
      S_WAIT: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(SETTLE - 1)) ? S_SAMPLE : S_WAIT;
      end
      S_SAMPLE: begin
        err_d  = err_q + 4'(mis);
        fv_d   = (mis && !fval_q) ? vec_q : fv_q;
        fval_d = fval_q | mis;
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = S_WAIT;
          vec_d   = vec_q + 3'd1;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign {a, b, c}  = vec_q;
  assign busy       = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fv_q;
  assign fail_valid = fval_q;
endmodule

// File: tb/tb_nor_pattern_checker.sv
// tb_nor_pattern_checker: scoreboard bench for two checker instances (SETTLE=1 and SETTLE=3)
module tb_nor_pattern_checker;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] start = '0, x = '0, a, b, c, busy, done, pass, fval;
  logic [3:0] err [2];
  logic [2:0] fvec [2];
  always #5 clk = ~clk;
  nor_pattern_checker #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .x(x[0]), .a(a[0]), .b(b[0]), .c(c[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]), .fail_vec(fvec[0]),
    .fail_valid(fval[0]));
  nor_pattern_checker #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .x(x[1]), .a(a[1]), .b(b[1]), .c(c[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]), .fail_vec(fvec[1]),
    .fail_valid(fval[1]));
  typedef struct {
    int         cyc;
    logic [3:0] err;
    logic [2:0] fv;
    logic       fval;
    logic       pass;
  } exp_t;
  exp_t       q [2][$];
  int         acc [2] = '{-1, -1};
  logic [7:0] flip [2] = '{8'h00, 8'h00};
  int         cyc = 0, errors = 0, checks = 0;
  bit         armed = 1'b0, noise = 1'b0;
  // cycles per vector (SETTLE+1) for each instance
  function automatic int per(int i);
    return (i == 0) ? 2 : 4;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // monitor: per-cycle busy/vector/done timing plus scoreboard compare on every done pulse
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int t;
      bit act, samp;
      logic [2:0] v;
      exp_t e;
      t    = cyc - acc[i];
      act  = acc[i] >= 0 && t >= 0 && t <= 8 * per(i);
      v    = 3'(t / per(i));
      samp = act && t < 8 * per(i) && (t % per(i)) == per(i) - 1;
      if (armed) begin
        if (act) begin
          chk("busy", busy[i], t < 8 * per(i));
          if (t < 8 * per(i)) chk("vec", {a[i], b[i], c[i]}, v);
          chk("done", done[i], t == 8 * per(i));
        end else begin
          chk("busy_idle", busy[i], 0);
          chk("done_idle", done[i], 0);
        end
        if (done[i] === 1'b1) begin
          if (q[i].size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q[i].pop_front();
            chk("done_cyc", cyc, e.cyc);
            chk("err_count", err[i], e.err);
            chk("fail_vec", fvec[i], e.fv);
            chk("fail_valid", fval[i], e.fval);
            chk("pass", pass[i], e.pass);
          end
        end
      end
      // NOR reply (with planted faults) only in the sample cycle; noise elsewhere
      x[i] = samp ? ((~|v) ^ flip[i][v]) : 1'($urandom);
    end
  end
  task automatic launch(int i, logic [7:0] f);
    exp_t e;
    int first;
    first = -1;
    for (int v = 7; v >= 0; v--) if (f[v]) first = v;
    flip[i] = f;
    e.err   = 4'($countones(f));
    e.fval  = (f != 8'h00);
    e.fv    = (first < 0) ? 3'd0 : 3'(first);
    e.pass  = (f == 8'h00);
    acc[i]  = cyc + 1;
    e.cyc   = acc[i] + 8 * per(i);
    q[i].push_back(e);
    start[i] = 1'b1;
  endtask
  task automatic wait_end(int i, bit hold);
    for (int n = 0; n < 300 && acc[i] >= 0 && cyc - acc[i] < 8 * per(i); n++) begin
      @(negedge clk); #1;
      if (!hold) start[i] = noise & 1'($urandom);
    end
    if (!hold) start[i] = 1'b0;
    if (acc[i] >= 0 && cyc - acc[i] < 8 * per(i)) begin
      chk("timeout", 1, 0);
      acc[i] = -1;
    end
  endtask
  task automatic run(int i, logic [7:0] f, bit hold);
    @(negedge clk); #1;
    launch(i, f);
    @(negedge clk); #1;
    if (!hold) start[i] = 1'b0;
    wait_end(i, hold);
    if (hold) begin
      @(negedge clk); #1;
      launch(i, f);
      @(negedge clk); #1;
      start[i] = 1'b0;
      wait_end(i, 1'b0);
    end
  endtask
  task automatic rst_vals(int i);
    chk("rst_abc", {a[i], b[i], c[i]}, 0);
    chk("rst_busy", busy[i], 0);
    chk("rst_done", done[i], 0);
    chk("rst_pass", pass[i], 0);
    chk("rst_err", err[i], 0);
    chk("rst_fvec", fvec[i], 0);
    chk("rst_fval", fval[i], 0);
  endtask
  initial begin
    start = 2'b11;
    repeat (3) @(negedge clk);
    rst_vals(0);
    rst_vals(1);
    start = 2'b00;
    rst_n = 1'b1;
    armed = 1'b1;
    run(0, 8'h00, 0);
    run(0, 8'h01, 0);
    run(0, 8'hFE, 0);
    run(0, 8'hFF, 0);
    run(0, 8'h24, 1);
    run(1, 8'h00, 0);
    run(1, 8'h5A, 0);
    @(negedge clk); #1;
    launch(0, 8'h01);
    @(negedge clk); #1;
    start[0] = 1'b0;
    for (int n = 0; n < 50 && cyc - acc[0] < 3 * per(0); n++) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    q[0].delete();
    acc[0] = -1;
    @(negedge clk); #1;
    rst_vals(0);
    rst_n = 1'b1;
    run(0, 8'h00, 0);
    noise = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int i;
      i = int'($urandom_range(0, 1));
      run(i, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 0);
    end
    repeat (3) @(negedge clk);
    chk("leftover0", q[0].size(), 0);
    chk("leftover1", q[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nor_pattern_checker.md
NOR_PATTERN_CHECKER -- requirements
Module: nor_pattern_checker

Interface
REQ-001 Parameter: SETTLE, 1, cycles that a driven vector is held before x is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: start  input  1  run request; sampled only in IDLE.
REQ-005 Port: x  input  1  result returned by the 3-input NOR under test.
REQ-006 Port: a, b, c  output  1 each  stimulus to the NOR under test; a=vec[2], b=vec[1], c=vec[0], driven from registered vector counter.
REQ-007 Port: busy  output  1  high from the cycle after start acceptance through the final SAMPLE cycle.
REQ-008 Port: done  output  1  one-cycle pulse at end of run.
REQ-009 Port: pass  output  1  result of last completed run: 1 when err_count==0; held until next start acceptance.
REQ-010 Port: err_count  output  4  number of mismatching vectors in the current/last run, 0..8.
REQ-011 Port: fail_vec  output  3  vector {a,b,c} of the first mismatch in the run.
REQ-012 Port: fail_valid  output  1  high once fail_vec holds a captured mismatch.

Function
REQ-013 FSM states: IDLE, WAIT, SAMPLE, DONE; encoding is free.
REQ-014 IDLE with start=1: next cycle state=WAIT, vec=0, wait counter=0, err_count=0, fail_valid=0, fail_vec=0, pass=0, busy=1.
REQ-015 IDLE with start=0: all outputs hold.
REQ-016 WAIT: wait counter increments each cycle; after exactly SETTLE cycles in WAIT, state moves to SAMPLE.
REQ-017 SAMPLE (one cycle): expected = ~(vec[2]|vec[1]|vec[0]); mismatch when x != expected.
REQ-018 On mismatch: err_count increments by 1; if fail_valid=0, fail_vec<=vec and fail_valid<=1; later mismatches do not overwrite fail_vec.
REQ-019 SAMPLE with vec!=7: vec increments, wait counter clears, state=WAIT.
REQ-020 SAMPLE with vec==7: state=DONE; vec does not wrap and holds 7.
REQ-021 DONE (one cycle): done=1, busy=0, pass=(err_count==0) including the final compare's update; next state IDLE.
REQ-022 Latency: start accepted at edge k -> done high in cycle k+1+8*(SETTLE+1); SETTLE=1 gives k+17.
REQ-023 start while busy, in DONE, or in the cycle done is high: ignored, no effect on run or counters.
REQ-024 x is only evaluated in SAMPLE; x activity in IDLE/WAIT/DONE has no effect.
REQ-025 err_count width covers max 8 errors; no saturation logic required, no wrap possible.
REQ-026 a, b, c change only on the SAMPLE->WAIT transition and at start acceptance; never glitch within a vector.

Reset
REQ-027 rst_n=0 at a rising edge: state=IDLE, vec=0 (a=b=c=0), busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0.
REQ-028 Reset mid-run (any state) aborts the run with the REQ-027 values next cycle; no done pulse is produced.
REQ-029 Reset has priority over start in the same cycle.

Verification
REQ-030 Correct NOR model on x, SETTLE=1, start pulse -> a,b,c step 000..111, done at k+17, pass=1, err_count=0, fail_valid=0.
REQ-031 x tied 0 -> err_count=1, fail_vec=000, fail_valid=1, pass=0.
REQ-032 x tied 1 -> err_count=7, fail_vec=001, pass=0; x=a|b|c -> err_count=8, fail_vec=000.
REQ-033 start held high throughout run -> exactly one run, done pulses once at k+17, then new run accepted in IDLE next cycle.
REQ-034 rst_n=0 for one cycle during vector 011 -> all outputs at reset values, no done; subsequent start completes a clean run with pass=1.
REQ-035 SETTLE=3, correct NOR -> each vector held 4 cycles, done at k+33, pass=1.
